// File: rtl/fb_port_controller_if.sv
// Client and frame-buffer signals of the frame buffer port controller.
// The controller takes the slave view; clients and memory take the master view.
interface fb_port_controller_if #(
  parameter int ADDR_W = 21
);
  logic              clear_start;
  logic [23:0]       clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic              wr_valid;
  logic              wr_ready;
  logic [10:0]       wr_x;
  logic [10:0]       wr_y;
  logic [23:0]       wr_data;
  logic              so_enable;
  logic              so_valid;
  logic              so_ready;
  logic [23:0]       so_data;
  logic              so_sof;
  logic              so_eol;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_wdata;
  logic [23:0]       fb_rdata;

  modport slave (
    input  clear_start, clear_color, wr_valid, wr_x, wr_y, wr_data,
           so_enable, so_ready, fb_rdata,
    output clear_busy, clear_done, wr_ready, so_valid, so_data, so_sof, so_eol,
           fb_we, fb_addr, fb_wdata
  );

  modport master (
    output clear_start, clear_color, wr_valid, wr_x, wr_y, wr_data,
           so_enable, so_ready, fb_rdata,
    input  clear_busy, clear_done, wr_ready, so_valid, so_data, so_sof, so_eol,
           fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/fb_port_controller.sv
// Shares the single frame buffer port between a bulk clear engine, a raster
// scan-out stream and a pixel writer; fb_* are registered one cycle after grant.
module fb_port_controller #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int ADDR_W = 21
) (
  input logic                 clk,
  input logic                 reset_n,
  fb_port_controller_if.slave bus
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = ADDR_W + 1;

  typedef enum logic {RUN, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [23:0]       clr_color_q, clr_color_d;
  logic [10:0]       x_q, x_d, y_q, y_d;
  logic              rr_q, rr_d;
  logic              inf_q, inf_d, inf_sof_q, inf_sof_d, inf_eol_q, inf_eol_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [23:0]       fb_wdata_q, fb_wdata_d;
  logic [25:0]       fifo_q [2];
  logic              wp_q, wp_d, rp_q, rp_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              so_req, wr_req, rd_gnt, wr_gnt, clr_last, wr_in_range, push, pop;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    x_d         = x_q;
    y_d         = y_q;
    rr_d        = rr_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    rd_gnt      = 1'b0;
    wr_gnt      = 1'b0;
    clr_last    = 1'b0;
    inf_sof_d   = (x_q == '0) && (y_q == '0);
    inf_eol_d   = (x_q == 11'(WIDTH - 1));
    // Reads in flight count against the two FIFO slots so the FIFO never overflows.
    so_req      = bus.so_enable && (({1'b0, cnt_q} + {2'b00, inf_q}) < 3'd2);
    wr_req      = bus.wr_valid;
    wr_in_range = (int'(bus.wr_x) < WIDTH) && (int'(bus.wr_y) < HEIGHT);
    case (state_q)
      RUN: begin
        if (reset_n && bus.clear_start) begin
          state_d     = CLEAR;
          clr_color_d = bus.clear_color;
          clr_cnt_d   = CW'(1);
          fb_we_d     = 1'b1;
          fb_addr_d   = '0;
          fb_wdata_d  = bus.clear_color;
        end else if (reset_n && so_req && !(wr_req && rr_q)) begin
          rd_gnt = 1'b1;
        end else if (reset_n && wr_req) begin
          wr_gnt = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CW'(TOTAL)) begin
          clr_last = 1'b1;
          state_d  = RUN;
        end else begin
          fb_we_d    = 1'b1;
          fb_addr_d  = clr_cnt_q[ADDR_W-1:0];
          fb_wdata_d = clr_color_q;
          clr_cnt_d  = clr_cnt_q + CW'(1);
        end
      end
    endcase
    if (rd_gnt) begin
      rr_d      = 1'b1;
      fb_addr_d = ADDR_W'(y_q) * ADDR_W'(WIDTH) + ADDR_W'(x_q);
      if (x_q == 11'(WIDTH - 1)) begin
        x_d = '0;
        y_d = (y_q == 11'(HEIGHT - 1)) ? '0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
    // Out-of-range writes are accepted but leave the bus idle.
    if (wr_gnt) begin
      rr_d = 1'b0;
      if (wr_in_range) begin
        fb_we_d    = 1'b1;
        fb_addr_d  = ADDR_W'(bus.wr_y) * ADDR_W'(WIDTH) + ADDR_W'(bus.wr_x);
        fb_wdata_d = bus.wr_data;
      end
    end
    if (!bus.so_enable && (cnt_q == 2'd0) && !inf_q) begin
      x_d = '0;
      y_d = '0;
    end
    inf_d = rd_gnt;
  end

  assign push  = inf_q;
  assign pop   = (cnt_q != 2'd0) && bus.so_ready;
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  assign wp_d  = wp_q ^ push;
  assign rp_d  = rp_q ^ pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      clr_cnt_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rr_q       <= 1'b0;
      inf_q      <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rr_q       <= rr_d;
      inf_q      <= inf_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      if (push) fifo_q[wp_q] <= {inf_sof_q, inf_eol_q, bus.fb_rdata};
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    clr_color_q <= clr_color_d;
    inf_sof_q   <= inf_sof_d;
    inf_eol_q   <= inf_eol_d;
  end

  assign bus.clear_busy = (state_q == CLEAR);
  assign bus.clear_done = clr_last;
  assign bus.wr_ready   = wr_gnt;
  assign bus.so_valid   = (cnt_q != 2'd0);
  assign bus.so_sof     = fifo_q[rp_q][25];
  assign bus.so_eol     = fifo_q[rp_q][24];
  assign bus.so_data    = fifo_q[rp_q][23:0];
  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_wdata   = fb_wdata_q;
endmodule

// File: tb/tb_fb_port_controller.sv
// Bench for fb_port_controller on an 8x4 buffer whose reads return the address
// as pixel data; fb writes are scoreboarded, scan-out follows a pixel-index model.
module tb_fb_port_controller;
  localparam int W      = 8;
  localparam int H      = 4;
  localparam int ADDR_W = 21;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [23:0]       d;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  fb_port_controller_if #(.ADDR_W(ADDR_W)) bus ();

  fb_port_controller #(.WIDTH(W), .HEIGHT(H), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  assign bus.fb_rdata = 24'(bus.fb_addr);

  int  total = 0;
  int  bad = 0;
  wr_t exp_wr[$];
  int  so_k = 0;
  int  done_seen = 0;
  bit  contend = 1'b0;
  bit  prev_wv = 1'b0;
  bit  prev_wr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_clear(input logic [23:0] color);
    wr_t e;
    for (int a = 0; a < W * H; a++) begin
      e.a = ADDR_W'(a);
      e.d = color;
      exp_wr.push_back(e);
    end
  endtask

  // Holds one write request until accepted; call at posedge+1.
  task automatic do_write(input int x, input int y, input logic [23:0] d);
    bit  got = 1'b0;
    wr_t e;
    bus.wr_x = 11'(x);
    bus.wr_y = 11'(y);
    bus.wr_data = d;
    bus.wr_valid = 1'b1;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        got = 1'b1;
        if (x < W && y < H) begin
          e.a = ADDR_W'(y * W + x);
          e.d = d;
          exp_wr.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    chk("wr_accept", 64'(got), 64'd1);
  endtask

  task automatic start_clear(input logic [23:0] color);
    @(posedge clk);
    #1;
    bus.clear_color = color;
    bus.clear_start = 1'b1;
    @(negedge clk);
    push_clear(color);
    @(posedge clk);
    #1;
    bus.clear_start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.fb_we) begin
        if (exp_wr.size() == 0) begin
          chk("fb_unexpected_write_addr", 64'(bus.fb_addr), 64'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("fb_addr", 64'(bus.fb_addr), 64'(e.a));
          chk("fb_wdata", 64'(bus.fb_wdata), 64'(e.d));
        end
      end
      if (bus.so_valid) begin
        chk("so_data", 64'(bus.so_data), 64'(so_k));
        chk("so_sof", 64'(bus.so_sof), 64'(so_k == 0));
        chk("so_eol", 64'(bus.so_eol), 64'((so_k % W) == W - 1));
        if (bus.so_ready) so_k = (so_k + 1) % (W * H);
      end
      if (bus.clear_busy) chk("wr_stalled_in_clear", 64'(bus.wr_ready), 64'd0);
      if (bus.clear_done) done_seen++;
      if (contend && bus.wr_valid && prev_wv) chk("alt_grant", 64'(bus.wr_ready), 64'(!prev_wr));
    end
    prev_wv = bus.wr_valid;
    prev_wr = bus.wr_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  busy_cnt, done_cnt, we_all, we_busy, done_base;
    logic [ADDR_W-1:0] prev_addr, done_addr;
    bit  got;

    reset_n = 1'b0;
    bus.clear_start = 1'b0;
    bus.clear_color = '0;
    bus.wr_valid = 1'b1;
    bus.wr_x = 11'd1;
    bus.wr_y = 11'd1;
    bus.wr_data = 24'h777777;
    bus.so_enable = 1'b1;
    bus.so_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clear_busy", 64'(bus.clear_busy), 0);
    chk("rst_clear_done", 64'(bus.clear_done), 0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 0);
    chk("rst_so_valid", 64'(bus.so_valid), 0);
    chk("rst_so_data", 64'(bus.so_data), 0);
    chk("rst_so_sof", 64'(bus.so_sof), 0);
    chk("rst_so_eol", 64'(bus.so_eol), 0);
    chk("rst_fb_we", 64'(bus.fb_we), 0);
    chk("rst_fb_addr", 64'(bus.fb_addr), 0);
    chk("rst_fb_wdata", 64'(bus.fb_wdata), 0);
    bus.so_enable = 1'b0;
    bus.wr_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_we", 64'(bus.fb_we), 0);
    end

    // Free-running scan-out, long enough to wrap the frame.
    @(posedge clk);
    #1 bus.so_enable = 1'b1;
    repeat (70) @(posedge clk);

    // Consumer stall.
    #1 bus.so_ready = 1'b0;
    n = 0;
    prev_addr = bus.fb_addr;
    repeat (10) begin
      @(negedge clk);
      if (bus.fb_addr != prev_addr) n++;
      prev_addr = bus.fb_addr;
    end
    chk("bp_reads_le2", 64'(n <= 2), 64'd1);
    @(posedge clk);
    #1 bus.so_ready = 1'b1;
    repeat (20) @(posedge clk);
    repeat (60) begin
      @(posedge clk);
      #1 bus.so_ready = 1'($urandom_range(0, 1));
    end
    bus.so_ready = 1'b1;
    repeat (5) @(posedge clk);

    // Writer competing with scan-out.
    #1 contend = 1'b1;
    do_write(3, 2, 24'hABCDEF);
    do_write(8, 0, 24'h123456);
    for (int i = 0; i < 10; i++)
      do_write(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)), 24'($urandom));
    contend = 1'b0;

    // Disable, drain, and confirm the raster restarts at (0,0).
    bus.so_enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("drained", 64'(bus.so_valid), 0);
    so_k = 0;
    bus.so_enable = 1'b1;
    repeat (15) @(posedge clk);
    #1 bus.so_enable = 1'b0;
    repeat (10) @(posedge clk);
    #1 so_k = 0;

    // Full clear racing a writer request in the same cycle.
    @(posedge clk);
    #1;
    bus.clear_color = 24'h102030;
    bus.clear_start = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    we_all = 0;
    we_busy = 0;
    done_addr = '0;
    fork
      do_write(1, 1, 24'h55AA55);
      begin
        @(negedge clk);
        chk("clear_beats_writer", 64'(bus.wr_ready), 0);
        push_clear(24'h102030);
        @(posedge clk);
        #1 bus.clear_start = 1'b0;
        repeat (40) begin
          @(negedge clk);
          if (bus.clear_busy) busy_cnt++;
          if (bus.fb_we) we_all++;
          if (bus.fb_we && bus.clear_busy) we_busy++;
          if (bus.clear_done) begin
            done_cnt++;
            done_addr = bus.fb_addr;
          end
        end
      end
    join
    chk("clear_busy_cycles", 64'(busy_cnt), 64'd32);
    chk("clear_we_in_busy", 64'(we_busy), 64'd32);
    chk("clear_plus_write_we", 64'(we_all), 64'd33);
    chk("clear_done_count", 64'(done_cnt), 64'd1);
    chk("clear_done_addr", 64'(done_addr), 64'd31);

    // Asynchronous reset partway through a clear.
    done_base = done_seen;
    start_clear(24'hC0FFEE);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.fb_we && bus.fb_addr == ADDR_W'(12)) got = 1'b1;
    end
    chk("reach_addr12", 64'(got), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy_low", 64'(bus.clear_busy), 0);
    chk("abort_done_low", 64'(bus.clear_done), 0);
    chk("abort_fb_we", 64'(bus.fb_we), 0);
    chk("abort_fb_addr", 64'(bus.fb_addr), 0);
    chk("abort_no_done", 64'(done_seen - done_base), 0);
    exp_wr.delete();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("after_abort_run", 64'(bus.clear_busy), 0);
    done_base = done_seen;
    start_clear(24'h0F0F0F);
    repeat (40) @(negedge clk);
    chk("restart_done_count", 64'(done_seen - done_base), 64'd1);
    chk("scoreboard_empty", 64'(exp_wr.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
